// File: rtl/ram64_loader_pkg.sv
// Shared widths and FSM state encoding for the RAM64 bulk loader.
package ram64_loader_pkg;
  localparam int RAM64_ADDR_W = 6;
  localparam int HACK_WORD_W  = 16;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_WRITE  = 3'd1,
    ST_VERIFY = 3'd2,
    ST_CHECK  = 3'd3,
    ST_DONE   = 3'd4
  } ldr_state_e;
endpackage

// File: rtl/ram64_loader_if.sv
// Loader control, upstream stream and RAM64 port bundle.
interface ram64_loader_if import ram64_loader_pkg::*; #(
  parameter int ADDR_W = RAM64_ADDR_W,
  parameter int DATA_W = HACK_WORD_W
);
  logic              start;
  logic [ADDR_W-1:0] base_addr;
  logic [ADDR_W:0]   count;
  logic [DATA_W-1:0] s_data;
  logic              s_valid;
  logic              s_ready;
  logic [DATA_W-1:0] ram_in;
  logic [ADDR_W-1:0] ram_addr;
  logic              ram_load;
  logic [DATA_W-1:0] ram_out;
  logic              busy;
  logic              done;
  logic              error;
  logic [DATA_W-1:0] err_sum;

  modport slave (
    input  start, base_addr, count, s_data, s_valid, ram_out,
    output s_ready, ram_in, ram_addr, ram_load, busy, done, error, err_sum
  );

  modport master (
    output start, base_addr, count, s_data, s_valid, ram_out,
    input  s_ready, ram_in, ram_addr, ram_load, busy, done, error, err_sum
  );
endinterface

// File: rtl/ram64_loader_sum16_acc.sv
// Wrapping additive checksum accumulator with synchronous clear.
module sum16_acc import ram64_loader_pkg::*; #(
  parameter int DATA_W = HACK_WORD_W
) (
  input  logic              clk,
  input  logic              clr_i,
  input  logic              en_i,
  input  logic [DATA_W-1:0] addend_i,
  output logic [DATA_W-1:0] sum_o
);
  logic [DATA_W-1:0] sum_q;

  always_ff @(posedge clk) begin
    if (clr_i)
      sum_q <= '0;
    else if (en_i)
      sum_q <= sum_q + addend_i;
  end

  assign sum_o = sum_q;
endmodule

// File: rtl/ram64_loader.sv
// Streams words into RAM64 from a base address, then reads the range back
// and compares additive checksums.
module ram64_loader import ram64_loader_pkg::*; #(
  parameter int ADDR_W = RAM64_ADDR_W,
  parameter int DATA_W = HACK_WORD_W
) (
  input logic           clk,
  input logic           reset,
  ram64_loader_if.slave bus
);
  localparam logic [ADDR_W:0] DEPTH = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0] ONE   = {{ADDR_W{1'b0}}, 1'b1};

  function automatic logic [ADDR_W:0] clamp_count(input logic [ADDR_W:0] c);
    return (c > DEPTH) ? DEPTH : c;
  endfunction

  ldr_state_e        state_q;
  logic [ADDR_W-1:0] ptr_q, base_q;
  logic [ADDR_W:0]   remaining_q, cnt_q;
  logic              s_ready_q, busy_q, done_q, error_q;
  logic [DATA_W-1:0] err_sum_q;

  logic [ADDR_W-1:0] ptr_d;
  logic [ADDR_W:0]   count_d;
  logic              hs, start_acc;
  logic [DATA_W-1:0] wsum, rsum;

  assign ptr_d     = ptr_q + 1'b1;
  assign count_d   = clamp_count(bus.count);
  assign hs        = s_ready_q & bus.s_valid;
  assign start_acc = (state_q == ST_IDLE) & bus.start;

  // A write is suppressed on a reset edge so a half-done transfer stops cleanly.
  assign bus.ram_load = hs & ~reset;
  assign bus.ram_in   = s_ready_q ? bus.s_data : '0;
  assign bus.ram_addr = ptr_q;
  assign bus.s_ready  = s_ready_q;
  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.error    = error_q;
  assign bus.err_sum  = err_sum_q;

  sum16_acc #(.DATA_W(DATA_W)) u_wsum (
    .clk      (clk),
    .clr_i    (start_acc),
    .en_i     (hs),
    .addend_i (bus.s_data),
    .sum_o    (wsum)
  );

  sum16_acc #(.DATA_W(DATA_W)) u_rsum (
    .clk      (clk),
    .clr_i    (start_acc),
    .en_i     (state_q == ST_VERIFY),
    .addend_i (bus.ram_out),
    .sum_o    (rsum)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      ptr_q       <= '0;
      base_q      <= '0;
      remaining_q <= '0;
      cnt_q       <= '0;
      s_ready_q   <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      error_q     <= 1'b0;
      err_sum_q   <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (bus.start) begin
            ptr_q       <= bus.base_addr;
            base_q      <= bus.base_addr;
            cnt_q       <= count_d;
            remaining_q <= count_d;
            error_q     <= 1'b0;
            err_sum_q   <= '0;
            busy_q      <= 1'b1;
            if (count_d == '0) begin
              state_q <= ST_DONE;
              done_q  <= 1'b1;
            end else begin
              state_q   <= ST_WRITE;
              s_ready_q <= 1'b1;
            end
          end
        end
        ST_WRITE: begin
          if (hs) begin
            if (remaining_q == ONE) begin
              state_q     <= ST_VERIFY;
              s_ready_q   <= 1'b0;
              ptr_q       <= base_q;
              remaining_q <= cnt_q;
            end else begin
              ptr_q       <= ptr_d;
              remaining_q <= remaining_q - ONE;
            end
          end
        end
        ST_VERIFY: begin
          ptr_q       <= ptr_d;
          remaining_q <= remaining_q - ONE;
          if (remaining_q == ONE)
            state_q <= ST_CHECK;
        end
        ST_CHECK: begin
          if (rsum != wsum) begin
            error_q   <= 1'b1;
            err_sum_q <= rsum;
          end
          state_q <= ST_DONE;
          done_q  <= 1'b1;
        end
        ST_DONE: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_ram64_loader.sv
// Drives the loader into a behavioural RAM64 and checks it against a reference model.
module tb_ram64_loader;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic corrupt = 1'b0;
  int   total = 0;
  int   bad = 0;
  int   load_cnt = 0;

  logic [15:0] mem [0:63];
  logic [15:0] model_mem [0:63];
  logic [15:0] words [$];
  int          bubs [$];

  ram64_loader_if bus ();

  ram64_loader dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  // RAM64: synchronous write, combinational read; the bench may overwrite word 5.
  always @(posedge clk) begin
    if (bus.ram_load)
      mem[bus.ram_addr] <= bus.ram_in;
    else if (corrupt)
      mem[5] <= 16'hFFFF;
  end
  assign bus.ram_out = mem[bus.ram_addr];

  always @(posedge clk)
    if (bus.ram_load) load_cnt <= load_cnt + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_ram(input string tag);
    int mism = 0;
    int first = -1;
    for (int i = 0; i < 64; i++)
      if (mem[i] !== model_mem[i]) begin
        mism++;
        if (first < 0) first = i;
      end
    chk({tag, " ram_mismatches(first addr ", $sformatf("%0d", first), ")"}, mism, 0);
  endtask

  task automatic fill_words(input int n, input int mode, input logic [15:0] seed);
    words.delete();
    bubs.delete();
    for (int i = 0; i < n; i++) begin
      case (mode)
        0:       words.push_back(16'($urandom));
        1:       words.push_back(seed + 16'(i));
        default: words.push_back(16'h0000);
      endcase
      bubs.push_back(0);
    end
  endtask

  task automatic do_xfer(input logic [5:0] b, input logic [6:0] c, input bit corrupt5,
                         input string tag);
    int n, cyc, widx, bub_left, nbub, lc0, limit, totbub, exp_lat;
    bit hs, cdone, exp_err;
    logic [15:0] wsum, rsum;
    n = (c > 7'd64) ? 64 : int'(c);
    totbub = 0;
    foreach (bubs[i]) totbub += bubs[i];
    @(negedge clk);
    bus.start = 1'b1;
    bus.base_addr = b;
    bus.count = c;
    bus.s_valid = 1'b0;
    lc0 = load_cnt;
    @(posedge clk); #1;
    bus.start = 1'b0;
    chk({tag, " busy_after_start"}, bus.busy, 1);
    cyc = 0;
    widx = 0;
    nbub = 0;
    cdone = 0;
    bub_left = (n > 0 && bubs.size() > 0) ? bubs[0] : 0;
    limit = 2 * n + totbub + 10;
    while (bus.done !== 1'b1 && cyc < limit) begin
      if (widx < n && bub_left == 0) begin
        bus.s_valid = 1'b1;
        bus.s_data = words[widx];
      end else begin
        bus.s_valid = 1'b0;
      end
      hs = bus.s_ready && bus.s_valid;
      if (bus.s_ready && !bus.s_valid) begin
        nbub++;
        if (bub_left > 0) bub_left--;
      end
      corrupt = corrupt5 && widx == n && !cdone;
      if (corrupt) cdone = 1;
      @(posedge clk); #1;
      cyc++;
      if (hs) begin
        widx++;
        bub_left = (widx < n && widx < bubs.size()) ? bubs[widx] : 0;
      end
    end
    bus.s_valid = 1'b0;
    corrupt = 1'b0;

    // Reference: words land at consecutive wrapping addresses; readback sums the range.
    wsum = '0;
    rsum = '0;
    for (int i = 0; i < n; i++) begin
      model_mem[(int'(b) + i) % 64] = words[i];
      wsum += words[i];
    end
    if (corrupt5) model_mem[5] = 16'hFFFF;
    for (int i = 0; i < n; i++) rsum += model_mem[(int'(b) + i) % 64];
    exp_err = (rsum != wsum);
    exp_lat = (n == 0) ? 0 : 2 * n + nbub + 1;

    chk({tag, " latency"}, cyc, exp_lat);
    chk({tag, " done_pulse"}, bus.done, 1);
    chk({tag, " busy_in_done"}, bus.busy, 1);
    chk({tag, " error"}, bus.error, exp_err);
    if (exp_err) chk({tag, " err_sum"}, bus.err_sum, rsum);
    chk({tag, " write_count"}, load_cnt - lc0, n);
    @(posedge clk); #1;
    chk({tag, " done_cleared"}, bus.done, 0);
    chk({tag, " busy_cleared"}, bus.busy, 0);
    chk({tag, " error_sticky"}, bus.error, exp_err);
    chk_ram(tag);
  endtask

  initial begin
    int lc0;
    bus.start = 1'b0;
    bus.base_addr = '0;
    bus.count = '0;
    bus.s_data = '0;
    bus.s_valid = 1'b0;
    for (int i = 0; i < 64; i++) model_mem[i] = 16'h0000;

    repeat (2) @(posedge clk);
    #1;
    chk("rst s_ready", bus.s_ready, 0);
    chk("rst ram_load", bus.ram_load, 0);
    chk("rst ram_in", bus.ram_in, 0);
    chk("rst ram_addr", bus.ram_addr, 0);
    chk("rst busy", bus.busy, 0);
    chk("rst done", bus.done, 0);
    chk("rst error", bus.error, 0);
    chk("rst err_sum", bus.err_sum, 0);
    @(negedge clk);
    reset = 1'b0;

    fill_words(64, 2, 16'h0);
    do_xfer(6'h00, 7'd64, 1'b0, "zero_fill");

    fill_words(4, 1, 16'h0001);
    do_xfer(6'h00, 7'd4, 1'b0, "basic");

    fill_words(4, 1, 16'hABCD);
    do_xfer(6'h3E, 7'd4, 1'b0, "wrap");
    chk("wrap mem0", mem[0], 16'hABCF);

    fill_words(3, 0, 16'h0);
    bubs[1] = 2;
    do_xfer(6'h10, 7'd3, 1'b0, "bubbles");

    fill_words(64, 0, 16'h0);
    do_xfer(6'h21, 7'd100, 1'b0, "clamp");

    fill_words(0, 0, 16'h0);
    do_xfer(6'h07, 7'd0, 1'b0, "zero_count");

    fill_words(8, 2, 16'h0);
    do_xfer(6'h00, 7'd8, 1'b1, "corrupt");
    chk("corrupt err_sum_ffff", bus.err_sum, 16'hFFFF);

    fill_words(5, 0, 16'h0);
    do_xfer(6'h30, 7'd5, 1'b0, "clears_error");

    // Reset after two of six words have been written.
    fill_words(6, 0, 16'h0);
    @(negedge clk);
    lc0 = load_cnt;
    bus.start = 1'b1;
    bus.base_addr = 6'd10;
    bus.count = 7'd6;
    @(posedge clk); #1;
    bus.start = 1'b0;
    for (int k = 0; k < 2; k++) begin
      bus.s_valid = 1'b1;
      bus.s_data = words[k];
      @(posedge clk); #1;
    end
    bus.s_data = words[2];
    reset = 1'b1;
    #1;
    chk("rstmid ram_load_gated", bus.ram_load, 0);
    @(posedge clk); #1;
    chk("rstmid busy", bus.busy, 0);
    chk("rstmid s_ready", bus.s_ready, 0);
    reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    bus.s_valid = 1'b0;
    chk("rstmid writes", load_cnt - lc0, 2);
    model_mem[10] = words[0];
    model_mem[11] = words[1];
    chk_ram("rstmid");

    fill_words(6, 0, 16'h0);
    do_xfer(6'd10, 7'd6, 1'b0, "after_reset");

    for (int t = 0; t < 6; t++) begin
      int nn;
      logic [6:0] cc;
      logic [5:0] bb;
      cc = 7'($urandom_range(70, 1));
      bb = 6'($urandom);
      nn = (cc > 7'd64) ? 64 : int'(cc);
      fill_words(nn, 0, 16'h0);
      for (int i = 0; i < nn; i++) bubs[i] = $urandom_range(2, 0);
      do_xfer(bb, cc, 1'b0, $sformatf("rand%0d", t));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
